// File: rtl/acq_sequencer.sv
// acq_sequencer
//    Sequences one capture around the trigger block: fills a pre-trigger
//    window, arms the trigger, records the trigger address, fills the
//    post-trigger window and reports done.
//
// Optional feature macro: AUTO_TRIG_EN
//    Defined     : in ARMED, a TO_W-bit sample counter forces a trigger when
//                  it reaches timeout (auto_mode=1); forced reports it.
//    Not defined : auto_mode/timeout ignored, forced tied to 0.
//
// Ports
//    CLK, nRST            clock (rising edge) and async active-low reset
//    start, abort         single-cycle capture request / cancel
//    decim                clk_en fires every decim+1 cycles while capturing
//    pre_len, post_len    pre/post-trigger sample counts (latched on start)
//    trig_in              trigger block trig_out
//    auto_mode, timeout   forced-trigger controls (AUTO_TRIG_EN)
//    clk_en, wr_en        sample enable and sample-RAM write strobe
//    wr_addr              sample-RAM write address
//    arm                  trigger enable (Start_Write & Enable_Trig)
//    trig_addr            wr_addr value when the trigger was taken
//    busy, done, forced   status
//    state                IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no capture; waits for start
// PRE   | writing pre-trigger samples, trigger ignored
// ARMED | arm=1, writing samples until trig_in (or timeout)
// POST  | writing post-trigger samples
// DONE  | capture complete, done held until next start/abort

module acq_sequencer #(
   parameter int ADDR_W = 10,
   parameter int TO_W   = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        decim,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   input  logic              trig_in,
   input  logic              auto_mode,
   input  logic [TO_W-1:0]   timeout,
   output logic              clk_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              arm,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              busy,
   output logic              done,
   output logic              forced,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [7:0]        decim_l;
   logic [7:0]        div_cnt;
   logic [ADDR_W-1:0] pre_len_l;
   logic [ADDR_W-1:0] post_len_l;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_cnt;

   logic active;
   logic next_active;
   logic tick;
   logic post_empty;
   logic en;
   logic start_ok;
   logic auto_hit;
   logic trig_hit;
   logic pre_last;
   logic post_last;

   always_comb begin
      state_d     = state_q;
      active      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
      tick        = (div_cnt == decim_l);
      // post_len=0: leave POST at once without writing a sample
      post_empty  = (state_q == S_POST) && (post_cnt == post_len_l);
      en          = active && tick && !abort && !post_empty;
      start_ok    = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
      trig_hit    = (state_q == S_ARMED) && !abort && (trig_in || auto_hit);
      pre_last    = en && (state_q == S_PRE) && ((pre_cnt + ADDR_W'(1)) == pre_len_l);
      post_last   = en && (state_q == S_POST) && ((post_cnt + ADDR_W'(1)) == post_len_l);

      if (abort) begin
         state_d = S_IDLE;
      end else if (start_ok) begin
         state_d = (pre_len == '0) ? S_ARMED : S_PRE;
      end else begin
         case (state_q)
            S_PRE:   if (pre_last) state_d = S_ARMED;
            S_ARMED: if (trig_hit) state_d = S_POST;
            S_POST:  if (post_empty || post_last) state_d = S_DONE;
            default: state_d = state_q;
         endcase
      end

      next_active = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         decim_l    <= '0;
         pre_len_l  <= '0;
         post_len_l <= '0;
         div_cnt    <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         wr_addr    <= '0;
         trig_addr  <= '0;
      end else begin
         // divider runs continuously across PRE/ARMED/POST, parked at 0 otherwise
         if (active && next_active) begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
         end else begin
            div_cnt <= '0;
         end

         if (start_ok) begin
            decim_l    <= decim;
            pre_len_l  <= pre_len;
            post_len_l <= post_len;
            wr_addr    <= '0;
            pre_cnt    <= '0;
         end else begin
            if (en) begin
               wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (en && (state_q == S_PRE)) begin
               pre_cnt <= pre_cnt + ADDR_W'(1);
            end
            if (trig_hit) begin
               trig_addr <= wr_addr;
               post_cnt  <= '0;
            end else if (en && (state_q == S_POST)) begin
               post_cnt <= post_cnt + ADDR_W'(1);
            end
         end
      end
   end

`ifdef AUTO_TRIG_EN
   logic [TO_W-1:0] to_cnt;
   logic            forced_q;

   assign auto_hit = auto_mode && (to_cnt == timeout);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         to_cnt   <= '0;
         forced_q <= 1'b0;
      end else begin
         if (state_q != S_ARMED) begin
            to_cnt <= '0;
         end else if (en) begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         if (start_ok) begin
            forced_q <= 1'b0;
         end else if (trig_hit) begin
            // a real trigger on the same cycle wins over the timeout
            forced_q <= !trig_in;
         end
      end
   end

   assign forced = forced_q;
`else
   logic unused_auto;
   assign unused_auto = ^{auto_mode, timeout};
   assign auto_hit    = 1'b0;
   assign forced      = 1'b0;
`endif

   assign clk_en = en;
   assign wr_en  = en;
   assign arm    = (state_q == S_ARMED);
   assign busy   = active;
   assign done   = (state_q == S_DONE);
   assign state  = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;

   localparam int AW = 4;
   localparam int TW = 16;
   localparam int DEPTH = 1 << AW;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    decim = '0;
   logic [AW-1:0] pre_len = '0;
   logic [AW-1:0] post_len = '0;
   logic          trig_in = 1'b0;
   logic          auto_mode = 1'b0;
   logic [TW-1:0] timeout = '0;
   logic          clk_en;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          arm;
   logic [AW-1:0] trig_addr;
   logic          busy;
   logic          done;
   logic          forced;
   logic [2:0]    state;

   acq_sequencer #(.ADDR_W(AW), .TO_W(TW)) dut (
      .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .decim(decim),
      .pre_len(pre_len), .post_len(post_len), .trig_in(trig_in),
      .auto_mode(auto_mode), .timeout(timeout), .clk_en(clk_en), .wr_en(wr_en),
      .wr_addr(wr_addr), .arm(arm), .trig_addr(trig_addr), .busy(busy),
      .done(done), .forced(forced), .state(state)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // phase: 0 idle, 1 pre, 2 armed, 3 post, 4 done
   // Sample enables are derived from the number of cycles since the capture
   // started (modulo decim+1) rather than from a wrapping divider.
   int m_ph = 0, m_tick = 0, m_d = 0, m_pre = 0, m_post = 0;
   int m_addr = 0, m_taddr = 0, m_npre = 0, m_npost = 0, m_narm = 0;
   int m_forced = 0;

   task automatic m_reset();
      m_ph = 0; m_tick = 0; m_d = 0; m_pre = 0; m_post = 0;
      m_addr = 0; m_taddr = 0; m_npre = 0; m_npost = 0; m_narm = 0; m_forced = 0;
   endtask

   function automatic int m_en();
      if (m_ph < 1 || m_ph > 3) return 0;
      if (abort) return 0;
      if (m_ph == 3 && m_post == 0) return 0;
      return ((m_tick % (m_d + 1)) == m_d) ? 1 : 0;
   endfunction

   task automatic m_step();
      int en;
      int hit_auto;
      en = m_en();
      hit_auto = 0;
      if (abort) begin
         m_ph = 0;
      end else if (start && (m_ph == 0 || m_ph == 4)) begin
         m_d = int'(decim); m_pre = int'(pre_len); m_post = int'(post_len);
         m_addr = 0; m_npre = 0; m_forced = 0; m_tick = 0; m_narm = 0;
         m_ph = (m_pre == 0) ? 2 : 1;
      end else if (m_ph == 1) begin
         m_tick++;
         if (en != 0) begin
            m_addr = (m_addr + 1) % DEPTH;
            m_npre++;
            if (m_npre == m_pre) begin m_ph = 2; m_narm = 0; end
         end
      end else if (m_ph == 2) begin
`ifdef AUTO_TRIG_EN
         hit_auto = (auto_mode && (m_narm == int'(timeout))) ? 1 : 0;
`endif
         m_tick++;
         if (trig_in || hit_auto != 0) begin
            m_taddr = m_addr;
            m_npost = 0;
            m_ph = 3;
            m_forced = trig_in ? 0 : 1;
         end
         if (en != 0) begin
            m_addr = (m_addr + 1) % DEPTH;
            m_narm++;
         end
      end else if (m_ph == 3) begin
         m_tick++;
         if (m_post == 0) begin
            m_ph = 4;
         end else if (en != 0) begin
            m_addr = (m_addr + 1) % DEPTH;
            m_npost++;
            if (m_npost == m_post) m_ph = 4;
         end
      end
   endtask

   // lockstep check at every falling edge, then advance the model with the
   // inputs that the next rising edge will see
   initial begin
      forever begin
         @(negedge CLK);
         if (!nRST) m_reset();
         check("m_state",     int'(state),     m_ph);
         check("m_clk_en",    int'(clk_en),    m_en());
         check("m_wr_en",     int'(wr_en),     m_en());
         check("m_wr_addr",   int'(wr_addr),   m_addr);
         check("m_arm",       int'(arm),       (m_ph == 2) ? 1 : 0);
         check("m_trig_addr", int'(trig_addr), m_taddr);
         check("m_busy",      int'(busy),      (m_ph >= 1 && m_ph <= 3) ? 1 : 0);
         check("m_done",      int'(done),      (m_ph == 4) ? 1 : 0);
         check("m_forced",    int'(forced),    m_forced);
         if (nRST) m_step();
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_state(input int s, input string nm);
      int n;
      n = 0;
      while (int'(state) != s && n < 400) begin
         step();
         n++;
      end
      check(nm, int'(state), s);
   endtask

   typedef struct {
      int decim;
      int pre;
      int post;
      int wait_armed;
      int exp_taddr;
      int exp_waddr;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input int idx);
      decim    = 8'(v.decim);
      pre_len  = AW'(v.pre);
      post_len = AW'(v.post);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_state(2, $sformatf("v%0d_armed", idx));
      repeat (v.wait_armed) step();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      wait_state(4, $sformatf("v%0d_done_state", idx));
      check($sformatf("v%0d_trig_addr", idx), int'(trig_addr), v.exp_taddr);
      check($sformatf("v%0d_wr_addr", idx), int'(wr_addr), v.exp_waddr);
      check($sformatf("v%0d_done", idx), int'(done), 1);
      check($sformatf("v%0d_busy", idx), int'(busy), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // decim, pre, post, ARMED cycles before trig, trig_addr, final wr_addr
      vecs[0] = '{2, 4, 3, 4, 5, 8};    // one ARMED write before trigger
      vecs[1] = '{0, 0, 0, 0, 0, 1};    // straight to ARMED, zero post writes
      vecs[2] = '{0, 14, 6, 0, 14, 5};  // address wraps 15->0
      vecs[3] = '{1, 3, 2, 2, 4, 6};
      vecs[4] = '{3, 1, 15, 0, 1, 0};   // post window wraps back to 0

      repeat (2) step();
      check("rst_state", int'(state), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_arm", int'(arm), 0);
      nRST = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // asynchronous reset in the middle of PRE
      decim = 8'd0; pre_len = AW'(10); post_len = AW'(2);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("midpre_state", int'(state), 1);
      check("midpre_wr_addr", int'(wr_addr), 3);
      #2 nRST = 1'b0;
      #1;
      check("arst_state", int'(state), 0);
      check("arst_wr_addr", int'(wr_addr), 0);
      check("arst_trig_addr", int'(trig_addr), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_clk_en", int'(clk_en), 0);
      check("arst_wr_en", int'(wr_en), 0);
      check("arst_arm", int'(arm), 0);
      check("arst_done", int'(done), 0);
      check("arst_forced", int'(forced), 0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      step();
      run_vec(vecs[0], 5);

      // trig_in high through PRE including the final write: ignored
      decim = 8'd0; pre_len = AW'(4); post_len = AW'(1);
      start = 1'b1; trig_in = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("tpre_state", int'(state), 1);
      check("tpre_arm", int'(arm), 0);
      check("tpre_last_wr", int'(wr_en), 1);
      step();
      trig_in = 1'b0;
      check("tpre_armed", int'(state), 2);
      check("tpre_arm_now", int'(arm), 1);
      repeat (4) step();
      check("tpre_still_armed", int'(state), 2);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      check("tpre_post", int'(state), 3);
      wait_state(4, "tpre_done");
      check("tpre_trig_addr", int'(trig_addr), 8);
      check("tpre_wr_addr", int'(wr_addr), 10);

      // start ignored mid-capture, abort in POST freezes wr_addr
      decim = 8'd1; pre_len = AW'(2); post_len = AW'(8);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_state(2, "ab_armed");
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      step();
      step();
      start = 1'b1; pre_len = AW'(5);
      step();
      start = 1'b0;
      check("ab_start_ignored", int'(state), 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_state", int'(state), 0);
      check("ab_done", int'(done), 0);
      check("ab_wr_addr", int'(wr_addr), 4);
      check("ab_trig_addr", int'(trig_addr), 2);
      repeat (3) step();
      check("ab_wr_addr_frozen", int'(wr_addr), 4);
      check("ab_clk_en", int'(clk_en), 0);

`ifdef AUTO_TRIG_EN
      decim = 8'd0; pre_len = AW'(1); post_len = AW'(2);
      auto_mode = 1'b1; timeout = TW'(10);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_state(2, "auto_armed");
      repeat (10) step();
      check("auto_before", int'(state), 2);
      step();
      check("auto_post", int'(state), 3);
      check("auto_forced", int'(forced), 1);
      check("auto_trig_addr", int'(trig_addr), 11);
      wait_state(4, "auto_done");
      check("auto_wr_addr", int'(wr_addr), 14);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_state(2, "auto2_armed");
      repeat (10) step();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      check("auto2_post", int'(state), 3);
      check("auto2_forced", int'(forced), 0);
      check("auto2_trig_addr", int'(trig_addr), 11);
      wait_state(4, "auto2_done");
      auto_mode = 1'b0;
`else
      decim = 8'd0; pre_len = AW'(0); post_len = AW'(0);
      auto_mode = 1'b1; timeout = TW'(0);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      check("noauto_armed", int'(state), 2);
      check("noauto_forced", int'(forced), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      auto_mode = 1'b0;
`endif

      // randomized traffic, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 19) == 0);
         abort     = ($urandom_range(0, 79) == 0);
         trig_in   = ($urandom_range(0, 11) == 0);
         decim     = 8'($urandom_range(0, 3));
         pre_len   = AW'($urandom_range(0, 15));
         post_len  = AW'($urandom_range(0, 15));
         auto_mode = ($urandom_range(0, 1) == 1);
         timeout   = TW'($urandom_range(0, 12));
         step();
      end
      start = 1'b0; abort = 1'b0; trig_in = 1'b0; auto_mode = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
